ir_sequencer: RTL
=================

IR_SEQUENCER -- requirements
Module: ir_sequencer

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 8, width of the pointer, memory word, device and address buses.
REQ-002 SHALL have clk  input  1  clock; all state updates on rising edge.
REQ-003 SHALL have rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have i_ir_mode  input  2  mode from controller: 00 idle, 01 reset, 10 work, 11 treated as idle.
REQ-005 SHALL have i_jump_en  input  1  load pointer from i_jump_addr.
REQ-006 SHALL have i_jump_addr  input  DATA_WIDTH  jump target word address.
REQ-007 SHALL have i_wait  input  1  hold before starting the next fetch.
REQ-008 SHALL have o_mem_addr  output  DATA_WIDTH  instruction memory word address.
REQ-009 SHALL have o_mem_rd  output  1  memory read request.
REQ-010 SHALL have i_mem_data  input  DATA_WIDTH  memory read data.
REQ-011 SHALL have i_mem_valid  input  1  i_mem_data valid this cycle.
REQ-012 SHALL have o_device  output  DATA_WIDTH  decoded device field.
REQ-013 SHALL have o_address  output  DATA_WIDTH  decoded address/port field.
REQ-014 SHALL have o_valid  output  1  o_device/o_address valid.
REQ-015 SHALL have i_ready  input  1  consumer accepts instruction.

Function
REQ-016 Instruction SHALL be two consecutive words: word at pointer P = device, word at P+1 = address.
REQ-017 States SHALL be RST, IDLE, FETCH_DEV, FETCH_ADDR, ISSUE.
REQ-018 RST: pointer and instruction-start register SHALL be 0; o_mem_rd=0, o_valid=0; exit to IDLE when i_ir_mode!=01.
REQ-019 i_ir_mode==01 in any state SHALL force RST on the next edge, overriding all other inputs.
REQ-020 IDLE: go to FETCH_DEV when i_ir_mode==10 and i_wait==0; otherwise stay.
REQ-021 On entering FETCH_DEV the instruction-start register SHALL capture the pointer.
REQ-022 FETCH_DEV/FETCH_ADDR: o_mem_rd=1 and o_mem_addr=pointer, held stable until i_mem_valid=1.
REQ-023 On i_mem_valid in FETCH_DEV: latch data into the device holding register, increment pointer, go to FETCH_ADDR.
REQ-024 On i_mem_valid in FETCH_ADDR: latch data into the address holding register, increment pointer, go to ISSUE.
REQ-025 Pointer increments SHALL wrap modulo 2^DATA_WIDTH (all-ones + 1 = 0).
REQ-026 ISSUE: o_valid=1; o_device and o_address SHALL be held stable until i_ready=1.
REQ-027 On o_valid&&i_ready: o_valid falls the next cycle; go to FETCH_DEV if mode==10 and i_wait==0, else IDLE.
REQ-028 Minimum latency with zero-wait memory: o_valid asserts 2 cycles after the FETCH_DEV entry edge; back-to-back throughput is one instruction per 3 cycles.
REQ-029 i_jump_en (mode!=01) SHALL load pointer from i_jump_addr on the next edge in any state except RST.
REQ-030 A jump in FETCH_DEV/FETCH_ADDR SHALL abort the fetch: the returned word is discarded, next state is FETCH_DEV at the new pointer.
REQ-031 A jump in ISSUE SHALL NOT drop the pending instruction; if the handshake completes in the same cycle, the jump target supplies the next pointer.
REQ-032 Mode change to 00/11 during FETCH_DEV/FETCH_ADDR SHALL abort: pointer restored to the instruction-start value, go to IDLE, o_mem_rd=0 next cycle.
REQ-033 Mode change to 00/11 during ISSUE SHALL keep o_valid asserted until handshake, then go to IDLE.
REQ-034 i_mem_valid outside fetch states SHALL be ignored.

Reset
REQ-035 While rst_n=0 at an edge: state=RST, pointer=0, o_mem_addr=0, o_mem_rd=0, o_device=0, o_address=0, o_valid=0.
REQ-036 rst_n low mid-fetch or mid-issue SHALL discard all in-flight data with no further memory or output activity.

Verification
REQ-037 Reset, mode 01->10, memory {0:0x03,1:0x05}, zero wait, i_ready=1 -> o_valid with dev=0x03, addr=0x05; pointer=2.
REQ-038 i_ready=0 for 4 cycles in ISSUE -> o_valid, o_device and o_address stable for 4 cycles; o_mem_rd=0 throughout.
REQ-039 Pointer=0xFF (DATA_WIDTH=8), fetch -> dev read from 0xFF, addr from 0x00; pointer ends at 0x01.
REQ-040 i_jump_en with i_jump_addr=0x40 during FETCH_ADDR -> word discarded; next o_mem_addr=0x40 in FETCH_DEV.
REQ-041 Mode 10->00 after device word accepted at P=0x10 -> IDLE; pointer=0x10; re-enable refetches from 0x10.
REQ-042 Mode 01 asserted during ISSUE -> o_valid=0 next cycle; pointer=0.

Source files
------------

// File: rtl/ir_sequencer.sv
// ir_sequencer -- fetches two-word (device, address) instructions and issues
// them to a consumer over a valid/ready handshake.  Revision 1.0
`default_nettype none

module ir_sequencer #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [1:0]            i_ir_mode,
  input  logic                  i_jump_en,
  input  logic [DATA_WIDTH-1:0] i_jump_addr,
  input  logic                  i_wait,
  output logic [DATA_WIDTH-1:0] o_mem_addr,
  output logic                  o_mem_rd,
  input  logic [DATA_WIDTH-1:0] i_mem_data,
  input  logic                  i_mem_valid,
  output logic [DATA_WIDTH-1:0] o_device,
  output logic [DATA_WIDTH-1:0] o_address,
  output logic                  o_valid,
  input  logic                  i_ready
);

  typedef enum logic [2:0] {
    ST_RST        = 3'd0,
    ST_IDLE       = 3'd1,
    ST_FETCH_DEV  = 3'd2,
    ST_FETCH_ADDR = 3'd3,
    ST_ISSUE      = 3'd4
  } state_t;

  localparam logic [DATA_WIDTH-1:0] PTR_STEP = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  state_t                state, state_nxt;
  logic [DATA_WIDTH-1:0] ptr, ptr_nxt;
  logic [DATA_WIDTH-1:0] start_ptr, start_ptr_nxt;
  logic [DATA_WIDTH-1:0] dev_reg, dev_reg_nxt;
  logic [DATA_WIDTH-1:0] addr_reg, addr_reg_nxt;
  logic                  mode_reset;
  logic                  mode_work;

  assign mode_reset = (i_ir_mode == 2'b01);
  assign mode_work  = (i_ir_mode == 2'b10);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= ST_RST;
      ptr       <= '0;
      start_ptr <= '0;
      dev_reg   <= '0;
      addr_reg  <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      start_ptr <= start_ptr_nxt;
      dev_reg   <= dev_reg_nxt;
      addr_reg  <= addr_reg_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    ptr_nxt       = ptr;
    start_ptr_nxt = start_ptr;
    dev_reg_nxt   = dev_reg;
    addr_reg_nxt  = addr_reg;

    if (mode_reset) begin
      state_nxt     = ST_RST;
      ptr_nxt       = '0;
      start_ptr_nxt = '0;
    end else begin
      if (i_jump_en && (state != ST_RST)) begin
        ptr_nxt = i_jump_addr;
      end

      case (state)
        ST_RST: begin
          state_nxt = ST_IDLE;
        end
        ST_IDLE: begin
          if (mode_work && !i_wait) begin
            state_nxt = ST_FETCH_DEV;
          end
        end
        ST_FETCH_DEV, ST_FETCH_ADDR: begin
          // Leaving work mode rewinds to the instruction start unless a jump
          // redirects the pointer in the same cycle.
          if (!mode_work) begin
            state_nxt = ST_IDLE;
            if (!i_jump_en) begin
              ptr_nxt = start_ptr;
            end
          end else if (i_jump_en) begin
            state_nxt = ST_FETCH_DEV;
          end else if (i_mem_valid) begin
            ptr_nxt = ptr + PTR_STEP;
            if (state == ST_FETCH_DEV) begin
              dev_reg_nxt = i_mem_data;
              state_nxt   = ST_FETCH_ADDR;
            end else begin
              addr_reg_nxt = i_mem_data;
              state_nxt    = ST_ISSUE;
            end
          end
        end
        ST_ISSUE: begin
          if (i_ready) begin
            state_nxt = (mode_work && !i_wait) ? ST_FETCH_DEV : ST_IDLE;
          end
        end
        default: begin
          state_nxt = ST_RST;
        end
      endcase

      // Every (re)entry into FETCH_DEV marks a new instruction start.
      if ((state_nxt == ST_FETCH_DEV) && ((state != ST_FETCH_DEV) || i_jump_en)) begin
        start_ptr_nxt = ptr_nxt;
      end
    end
  end

  assign o_mem_addr = ptr;
  assign o_mem_rd   = (state == ST_FETCH_DEV) || (state == ST_FETCH_ADDR);
  assign o_valid    = (state == ST_ISSUE);
  assign o_device   = dev_reg;
  assign o_address  = addr_reg;

endmodule

`default_nettype wire
